// File: rtl/morse_pkg.sv
// morse_pkg: shared Morse FSM states, timing multiples and digit code table
package morse_pkg;
    typedef enum logic [2:0] {S_IDLE, S_MARK, S_SPACE, S_DECODE, S_ABORT} state_t;
    localparam int DASH_UNITS  = 2;
    localparam int GAP_UNITS   = 3;
    localparam int ABORT_UNITS = 7;
    localparam int SYM_MAX     = 5;
    // index is the digit; first-sent symbol sits in bit 4, dash = 1
    localparam logic [4:0] DIGIT_PAT [10] = '{
        5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001,
        5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110
    };
endpackage

// File: rtl/morse_digit_lut.sv
// morse_digit_lut: maps a 5-symbol pattern to its digit, ok low when unknown
module morse_digit_lut
    import morse_pkg::*;
(
    input  logic [4:0] pattern,
    output logic [3:0] digit,
    output logic       ok
);
    always_comb begin
        digit = '0;
        ok    = 1'b0;
        for (int i = 0; i < 10; i++)
            if (pattern == DIGIT_PAT[i]) begin
                digit = 4'(i);
                ok    = 1'b1;
            end
    end
endmodule

// File: rtl/morse_recv.sv
// morse_recv: times key marks/gaps into dots and dashes and decodes 5-symbol digits
module morse_recv
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       err,
    output logic [4:0] sym_bits,
    output logic [2:0] sym_cnt,
    output logic       busy,
    output logic       beep
);
    localparam int CW = $clog2(ABORT_UNITS * UNIT_CYCLES + 1);
    localparam logic [CW-1:0] DASH_L  = CW'(DASH_UNITS * UNIT_CYCLES);
    localparam logic [CW-1:0] GAP_L   = CW'(GAP_UNITS * UNIT_CYCLES);
    localparam logic [CW-1:0] ABORT_L = CW'(ABORT_UNITS * UNIT_CYCLES);
    state_t state;
    logic [CW-1:0] mcnt, gcnt, mcnt_nx, gcnt_nx;
    logic ovf, lut_ok;
    logic [3:0] lut_digit;
    morse_digit_lut u_lut (.pattern(sym_bits), .digit(lut_digit), .ok(lut_ok));
    assign mcnt_nx = mcnt + CW'(mcnt != ABORT_L);
    assign gcnt_nx = gcnt + CW'(gcnt != ABORT_L);
    assign busy    = state != S_IDLE;
    assign beep    = key & ~rst;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            mcnt        <= '0;
            gcnt        <= '0;
            ovf         <= 1'b0;
            sym_bits    <= '0;
            sym_cnt     <= '0;
            digit       <= '0;
            digit_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            digit_valid <= 1'b0;
            err         <= 1'b0;
            case (state)
                S_IDLE:
                    if (key) begin
                        state <= S_MARK;
                        mcnt  <= CW'(1);
                    end
                S_MARK:
                    if (!key) begin
                        state <= S_SPACE;
                        gcnt  <= CW'(1);
                        if (sym_cnt == 3'(SYM_MAX)) ovf <= 1'b1;
                        else begin
                            sym_bits <= {sym_bits[3:0], mcnt >= DASH_L};
                            sym_cnt  <= sym_cnt + 3'd1;
                        end
                    end else if (mcnt_nx == ABORT_L) begin
                        state    <= S_ABORT;
                        err      <= 1'b1;
                        sym_bits <= '0;
                        sym_cnt  <= '0;
                        ovf      <= 1'b0;
                    end else mcnt <= mcnt_nx;
                S_SPACE:
                    if (key) begin
                        state <= S_MARK;
                        mcnt  <= CW'(1);
                    end else begin
                        gcnt <= gcnt_nx;
                        if (gcnt_nx == GAP_L) state <= S_DECODE;
                    end
                S_DECODE: begin
                    // key is ignored here; IDLE picks up a held key one cycle later
                    if (lut_ok && sym_cnt == 3'(SYM_MAX) && !ovf) begin
                        digit       <= lut_digit;
                        digit_valid <= 1'b1;
                    end else err <= 1'b1;
                    state    <= S_IDLE;
                    sym_bits <= '0;
                    sym_cnt  <= '0;
                    ovf      <= 1'b0;
                end
                S_ABORT:
                    if (!key) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_morse_recv.sv
// tb_morse_recv: directed and random characters checked against a symbol-level Morse model
module tb_morse_recv;
    localparam int U = 4;
    logic clk = 1'b0, rst = 1'b1, key = 1'b0;
    logic [3:0] digit;
    logic digit_valid, err, busy, beep;
    logic [4:0] sym_bits;
    logic [2:0] sym_cnt;
    int checks = 0, errors = 0, cyc = 0, exp_digit = 0;
    int ev_c[$], ev_k[$], ev_d[$], ev_s[$];
    int mk[$], gp[$];

    morse_recv #(.UNIT_CYCLES(U)) dut (
        .clk(clk), .rst(rst), .key(key), .digit(digit), .digit_valid(digit_valid),
        .err(err), .sym_bits(sym_bits), .sym_cnt(sym_cnt), .busy(busy), .beep(beep)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        check("exclusive", 32'(digit_valid & err), 0);
        if (digit_valid || err) begin
            ev_c.push_back(cyc);
            ev_k.push_back(err ? 1 : 0);
            ev_d.push_back(int'(digit));
            ev_s.push_back(int'(sym_cnt));
        end
    end

    // digit d: 1-5 = d dots then dashes, 6-9 = (d-5) dashes then dots, 0 = all dashes
    function automatic logic [4:0] digit_pattern(input int d);
        logic [4:0] p;
        p = '0;
        for (int k = 0; k < 5; k++) p[4-k] = (d == 0) || (d <= 5 ? k >= d : k < d - 5);
        return p;
    endfunction

    function automatic int ref_decode(input logic [4:0] p);
        for (int d = 0; d < 10; d++) if (digit_pattern(d) == p) return d;
        return -1;
    endfunction

    task automatic hold(input logic v, input int n);
        key = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        ev_c.delete(); ev_k.delete(); ev_d.delete(); ev_s.delete();
    endtask

    task automatic expect_one(input int kind, input int c);
        check("ev_count", ev_c.size(), 1);
        if (ev_c.size() > 0) begin
            check("ev_cycle", ev_c[0], c);
            check("ev_kind", ev_k[0], kind);
            check("ev_digit", ev_d[0], exp_digit);
            check("ev_symcnt", ev_s[0], 0);
        end
        check("digit", digit, exp_digit);
    endtask

    task automatic run_char(input int fin);
        int n, rel, d;
        logic [4:0] pat;
        n = mk.size();
        pat = '0;
        for (int i = 0; i < n && i < 5; i++) pat = {pat[3:0], mk[i] >= 2 * U};
        d = (n == 5) ? ref_decode(pat) : -1;
        clear_events();
        for (int i = 0; i < n; i++) begin
            hold(1'b1, mk[i]);
            if (i < n - 1) hold(1'b0, gp[i]);
        end
        rel = cyc + 1;
        hold(1'b0, 6);
        check("sym_cnt", sym_cnt, n < 5 ? n : 5);
        check("sym_bits", sym_bits, pat);
        check("busy_space", busy, 1);
        hold(1'b0, fin - 6);
        if (d >= 0) exp_digit = d;
        expect_one(d >= 0 ? 0 : 1, rel + 3 * U);
        check("sym_cnt_clr", sym_cnt, 0);
        check("busy_idle", busy, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_digit"}, digit, 0);
        check({tag, "_valid"}, digit_valid, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_bits"}, sym_bits, 0);
        check({tag, "_cnt"}, sym_cnt, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_beep"}, beep, 0);
    endtask

    initial begin
        int r1, r2, s, d, n;
        logic [4:0] p;
        key = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        key = 1'b0;
        rst = 1'b0;
        hold(1'b0, 3);

        mk = '{12, 12, 12, 12, 12}; gp = '{4, 4, 4, 4};
        run_char(20);
        mk = '{4, 4, 4, 4, 12}; gp = '{4, 4, 4, 4};
        run_char(20);
        mk = '{4, 4, 4, 4, 4, 4}; gp = '{4, 4, 4, 4, 4};
        run_char(20);

        hold(1'b1, 4); hold(1'b0, 4); hold(1'b1, 4); hold(1'b0, 4); hold(1'b1, 4); hold(1'b0, 2);
        check("pre_rst_cnt", sym_cnt, 3);
        check("pre_rst_digit", digit, 4);
        #2;
        rst = 1'b1;
        key = 1'b1;
        #1;
        check_zero("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        key = 1'b0;
        exp_digit = 0;
        hold(1'b0, 3);
        mk = '{4, 4, 4, 4, 4}; gp = '{4, 4, 4, 4};
        run_char(20);

        mk = '{7, 8, 8, 8, 8}; gp = '{4, 4, 4, 4};
        run_char(16);
        mk = '{8, 7, 7, 7, 7}; gp = '{11, 11, 11, 11};
        run_char(16);

        clear_events();
        hold(1'b1, 4);
        r1 = cyc + 1;
        hold(1'b0, 12);
        hold(1'b1, 4);
        r2 = cyc + 1;
        hold(1'b0, 6);
        check("gap12_cnt", sym_cnt, 1);
        hold(1'b0, 14);
        check("gap12_events", ev_c.size(), 2);
        if (ev_c.size() == 2) begin
            check("gap12_ev0", ev_c[0], r1 + 3 * U);
            check("gap12_ev1", ev_c[1], r2 + 3 * U);
            check("gap12_kind", ev_k[0] + ev_k[1], 2);
        end

        clear_events();
        s = cyc + 1;
        hold(1'b1, 40);
        check("abort_busy", busy, 1);
        check("abort_cnt", sym_cnt, 0);
        expect_one(1, s + 7 * U - 1);
        hold(1'b0, 1);
        check("abort_idle", busy, 0);
        hold(1'b0, 16);
        check("abort_no_decode", ev_c.size(), 1);

        for (int t = 0; t < 40; t++) begin
            mk.delete();
            gp.delete();
            if ($urandom_range(0, 3) != 0) begin
                d = $urandom_range(0, 9);
                p = digit_pattern(d);
                for (int k = 0; k < 5; k++)
                    mk.push_back(p[4-k] ? $urandom_range(2 * U, 7 * U - 1) : $urandom_range(1, 2 * U - 1));
            end else begin
                n = $urandom_range(1, 7);
                for (int k = 0; k < n; k++) mk.push_back($urandom_range(1, 7 * U - 1));
            end
            for (int k = 1; k < mk.size(); k++) gp.push_back($urandom_range(1, 3 * U - 1));
            run_char($urandom_range(14, 20));
        end

        rst = 1'b1;
        key = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b1, 8);
        hold(1'b0, 3);
        check("rel_mark_cnt", sym_cnt, 1);
        check("rel_mark_dash", sym_bits, 1);
        hold(1'b0, 20);
        check("rel_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
